muladd_seq: RTL

- Multi-cycle sequencer for the MADD/MADDU/MSUB/MSUBU instructions in the EX stage.
- On an accepted operation it holds the pipeline through stallreq and computes the 64-bit product iteratively, BITS_PER_CYCLE bits per cycle.
- It then accumulates the product into, or subtracts it from, {hi,lo] and presents the HI/LO write to the EX/MEM path.
- Exports cnt and hilo_tempt, which travel down the pipeline with the instruction.

---
 rtl/muladd_defs_pkg.sv | 37 +++
 rtl/muladd_step.sv | 26 ++
 rtl/muladd_seq.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/muladd_defs_pkg.sv
// Shared encodings and small helpers for the MADD-class multi-cycle sequencer.
// Op, state and width constants are used by both the top and the step adder.
package muladd_defs;

  localparam int HILO_W = 64;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 5;

  typedef enum logic [1:0] {
    OP_MADD  = 2'b00,
    OP_MADDU = 2'b01,
    OP_MSUB  = 2'b10,
    OP_MSUBU = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_MUL  = 3'd2,
    ST_ACC  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic op_is_sub(input op_e op);
    return (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  // Two's-complement magnitude; 0x80000000 maps to itself, which is correct as unsigned.
  function automatic logic [DATA_W-1:0] abs32(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? (~v + {{(DATA_W-1){1'b0}}, 1'b1}) : v;
  endfunction

endpackage

// File: rtl/muladd_step.sv
// One radix-2^BITS_PER_CYCLE iteration: acc + ((mcand * digit) << shift).
// The caller guarantees the running sum never exceeds 64 bits.
module muladd_step
  import muladd_defs::*;
#(
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic [HILO_W-1:0]         acc_i,
  input  logic [DATA_W-1:0]         mcand_i,
  input  logic [BITS_PER_CYCLE-1:0] digit_i,
  input  logic [5:0]                shift_i,
  output logic [HILO_W-1:0]         sum_o
);

  localparam int PP_W = DATA_W + BITS_PER_CYCLE;

  logic [PP_W-1:0]   pp;
  logic [HILO_W-1:0] pp_ext;

  always_comb begin
    pp     = {{BITS_PER_CYCLE{1'b0}}, mcand_i} * {{DATA_W{1'b0}}, digit_i};
    pp_ext = {{(HILO_W-PP_W){1'b0}}, pp};
    sum_o  = acc_i + (pp_ext << shift_i);
  end

endmodule

// File: rtl/muladd_seq.sv
// EX-stage sequencer for MADD/MADDU/MSUB/MSUBU: iterative 32x32 multiply,
// then accumulate into / subtract from {hi,lo}, holding the pipeline meanwhile.
module muladd_seq
  import muladd_defs::*;
#(
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] opa,
  input  logic [DATA_W-1:0] opb,
  input  logic [DATA_W-1:0] hi_in,
  input  logic [DATA_W-1:0] lo_in,
  input  logic              stall_in,
  input  logic              flush,
  output logic              stallreq,
  output logic              hilo_we,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  output logic [CNT_W-1:0]  cnt,
  output logic [HILO_W-1:0] hilo_tempt,
  output logic              busy,
  output state_e            dbg_state
);

  localparam int              ITER       = DATA_W / BITS_PER_CYCLE;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(ITER - 1);
  localparam logic [5:0]       SHIFT_STEP = 6'(BITS_PER_CYCLE);

  // Handshake: stallreq is asserted from the accept cycle through ACC and is
  // dropped in DONE; hilo_we is a registered valid, high exactly while in DONE,
  // carrying identical hi_out/lo_out for every cycle that stall_in holds DONE.

  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  logic [DATA_W-1:0]     mcand_q, mcand_d;
  logic [DATA_W-1:0]     mplier_q, mplier_d;
  logic [HILO_W-1:0]     acc_q, acc_d;
  logic                  neg_q, neg_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [HILO_W-1:0]     tempt_q, tempt_d;
  logic [DATA_W-1:0]     hi_q, hi_d;
  logic [DATA_W-1:0]     lo_q, lo_d;
  logic                  we_q, we_d;

  logic [5:0]            shift;
  logic [HILO_W-1:0]     step_sum;
  logic [HILO_W-1:0]     prod;
  logic [HILO_W-1:0]     result;

  assign shift = {1'b0, cnt_q} * SHIFT_STEP;

  muladd_step #(
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_step (
    .acc_i   (tempt_q),
    .mcand_i (mcand_q),
    .digit_i (mplier_q[BITS_PER_CYCLE-1:0]),
    .shift_i (shift),
    .sum_o   (step_sum)
  );

  always_comb begin
    prod   = neg_q ? -tempt_q : tempt_q;
    result = op_is_sub(op_q) ? (acc_q - prod) : (acc_q + prod);
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    tempt_d  = tempt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    stallreq = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          stallreq = 1'b1;
          op_d     = op_e'(op);
          mcand_d  = opa;
          mplier_d = opb;
          acc_d    = {hi_in, lo_in};
          state_d  = ST_PREP;
        end
      end
      ST_PREP: begin
        stallreq = 1'b1;
        if (op_is_signed(op_q)) begin
          mcand_d  = abs32(mcand_q);
          mplier_d = abs32(mplier_q);
          neg_d    = mcand_q[DATA_W-1] ^ mplier_q[DATA_W-1];
        end else begin
          neg_d = 1'b0;
        end
        tempt_d = '0;
        cnt_d   = '0;
        state_d = ST_MUL;
      end
      ST_MUL: begin
        stallreq = 1'b1;
        tempt_d  = step_sum;
        mplier_d = mplier_q >> BITS_PER_CYCLE;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) state_d = ST_ACC;
      end
      ST_ACC: begin
        stallreq = 1'b1;
        tempt_d  = prod;
        hi_d     = result[HILO_W-1:DATA_W];
        lo_d     = result[DATA_W-1:0];
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        // start stays high while EX is held; only stall_in decides when to leave.
        if (!stall_in) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      stallreq = 1'b0;
    end

    we_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MADD;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      tempt_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      tempt_q  <= tempt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      we_q     <= we_d;
    end
  end

  assign hilo_we    = we_q;
  assign hi_out     = hi_q;
  assign lo_out     = lo_q;
  assign cnt        = cnt_q;
  assign hilo_tempt = tempt_q;
  assign busy       = (state_q != ST_IDLE);
  assign dbg_state  = state_q;

endmodule
